// File: rtl/cache_fill_fsm.sv
// Cache line fill sequencer: on a miss, issues WORDS back-to-back word reads to a
// pipelined memory, writes each returned word into the data array and the tag with the last.
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic                     memory_data_valid,
  output logic                     fsm_busy,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        memory_address,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] word_index,
  output logic                     write_tag_array
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW:0]         WORDS_C    = (IW+1)'(WORDS);
  localparam logic [IW-1:0]       LAST_C     = IW'(WORDS - 1);
  localparam logic [ADDR_W-1:0]   ALIGN_MASK = ~ADDR_W'((1 << (IW + 1)) - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [IW:0]       issue_cnt, issue_nxt;
  logic [IW-1:0]     recv_cnt, recv_nxt;
  // Low for the first cycle after reset release so every output stays quiet then.
  logic              armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      base      <= base_nxt;
      issue_cnt <= issue_nxt;
      recv_cnt  <= recv_nxt;
      armed     <= 1'b1;
    end
  end

  always_comb begin
    state_nxt        = state;
    base_nxt         = base;
    issue_nxt        = issue_cnt;
    recv_nxt         = recv_cnt;
    fsm_busy         = 1'b0;
    mem_req          = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;

    unique case (state)
      IDLE: begin
        if (armed && miss_detected) begin
          fsm_busy  = 1'b1;
          state_nxt = FILL;
          base_nxt  = miss_address & ALIGN_MASK;
          issue_nxt = '0;
          recv_nxt  = '0;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt < WORDS_C) begin
          mem_req        = 1'b1;
          memory_address = base + ADDR_W'({issue_cnt, 1'b0});
          issue_nxt      = issue_cnt + 1'b1;
        end
        // Returns are counted independently of issue; completion waits on the last valid only.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_index       = recv_cnt;
          recv_nxt         = recv_cnt + 1'b1;
          if (recv_cnt == LAST_C) begin
            write_tag_array = 1'b1;
            state_nxt       = IDLE;
            issue_nxt       = '0;
            recv_nxt        = '0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a vector table for the 4-cycle fill plus
// hand-written sequences driving a small pipelined memory responder model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic        write_tag_array;

  int n_compared = 0;
  int n_mismatched = 0;

  cache_fill_fsm #(.WORDS(8), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          miss;
    logic [15:0] addr;
    bit          valid;
    bit          busy;
    bit          req;
    logic [15:0] maddr;
    bit          wr;
    logic [2:0]  idx;
    bit          tag;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string name, input bit busy, input bit req, input logic [15:0] maddr,
                          input bit wr, input logic [2:0] idx, input bit tag);
    checkOutput({name, ".busy"}, int'(fsm_busy), int'(busy));
    checkOutput({name, ".req"}, int'(mem_req), int'(req));
    checkOutput({name, ".maddr"}, int'(memory_address), int'(maddr));
    checkOutput({name, ".wr"}, int'(write_data_array), int'(wr));
    checkOutput({name, ".idx"}, int'(word_index), int'(idx));
    checkOutput({name, ".tag"}, int'(write_tag_array), int'(tag));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input bit miss, input logic [15:0] addr, input bit valid);
    @(negedge clk);
    miss_detected     = miss;
    miss_address      = addr;
    memory_data_valid = valid;
    #1;
  endtask

  task automatic doReset(input string name);
    @(negedge clk);
    rst = 1'b1;
    miss_detected = 1'b1;
    memory_data_valid = 1'b1;
    #1;
    checkAll({name, ".high"}, 0, 0, 16'h0, 0, 3'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll({name, ".first"}, 0, 0, 16'h0, 0, 3'd0, 0);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkAll({name, ".after"}, 0, 0, 16'h0, 0, 3'd0, 0);
    applyStimulus(1'b0, 16'h0, 1'b0);
  endtask

  // Full fill against a 4-cycle memory that may insert gap cycles between valids.
  task automatic runFill(input string name, input logic [15:0] miss_addr, input logic [15:0] exp_base,
                         input int gap, input bit hold_miss, input logic [15:0] later_addr);
    int ready[$];
    int next_ok = 0;
    int req_n = 0;
    int wr_n = 0;
    int tag_n = 0;
    bit done = 0;
    bit v;
    logic [15:0] exp_addr;
    applyStimulus(1'b1, miss_addr, 1'b0);
    checkOutput({name, ".start.busy"}, int'(fsm_busy), 1);
    checkOutput({name, ".start.req"}, int'(mem_req), 0);
    for (int c = 1; c <= 200 && !done; c++) begin
      v = (ready.size() > 0) && (ready[0] <= c) && (c >= next_ok);
      if (v) begin
        void'(ready.pop_front());
        next_ok = c + 1 + gap;
      end
      applyStimulus(hold_miss, (c >= 4) ? later_addr : miss_addr, v);
      checkOutput({name, ".busy"}, int'(fsm_busy), 1);
      if (mem_req) begin
        exp_addr = exp_base + 16'(2 * req_n);
        checkOutput({name, ".addr"}, int'(memory_address), int'(exp_addr));
        req_n++;
        ready.push_back(c + 4);
      end
      checkOutput({name, ".wr"}, int'(write_data_array), int'(v));
      if (v) begin
        checkOutput({name, ".idx"}, int'(word_index), wr_n % 8);
        wr_n++;
      end
      checkOutput({name, ".tag"}, int'(write_tag_array), int'(v && wr_n == 8));
      if (write_tag_array) begin
        tag_n++;
        done = 1;
      end
    end
    checkOutput({name, ".reqs"}, req_n, 8);
    checkOutput({name, ".writes"}, wr_n, 8);
    checkOutput({name, ".tags"}, tag_n, 1);
  endtask

  initial begin
    int wr_n;
    int tag_n;
    bit v;

    for (int c = 0; c < 14; c++) begin
      vecs[c].miss  = (c == 0);
      vecs[c].addr  = 16'h1234;
      vecs[c].valid = (c >= 5 && c <= 12);
      vecs[c].busy  = (c <= 12);
      vecs[c].req   = (c >= 1 && c <= 8);
      vecs[c].maddr = vecs[c].req ? 16'(16'h1230 + 2 * (c - 1)) : 16'h0;
      vecs[c].wr    = vecs[c].valid;
      vecs[c].idx   = vecs[c].valid ? 3'(c - 5) : 3'd0;
      vecs[c].tag   = (c == 12);
    end

    $display("[TB] reset and release");
    doReset("reset");

    $display("[TB] 4-cycle fill at 0x1234");
    for (int c = 0; c < 14; c++) begin
      applyStimulus(vecs[c].miss, vecs[c].addr, vecs[c].valid);
      checkAll($sformatf("table.c%0d", c), vecs[c].busy, vecs[c].req, vecs[c].maddr,
               vecs[c].wr, vecs[c].idx, vecs[c].tag);
    end

    $display("[TB] fill with gaps between valids");
    runFill("gaps", 16'h1234, 16'h1230, 2, 1'b0, 16'h1234);
    applyStimulus(1'b0, 16'h1234, 1'b0);
    checkOutput("gaps.idle.busy", int'(fsm_busy), 0);

    $display("[TB] miss held, address changed mid-fill");
    runFill("hold", 16'h1234, 16'h1230, 0, 1'b1, 16'h4000);
    runFill("next", 16'h4000, 16'h4000, 0, 1'b0, 16'h4000);
    applyStimulus(1'b0, 16'h4000, 1'b0);
    checkOutput("next.idle.busy", int'(fsm_busy), 0);

    $display("[TB] reset after three returned words");
    wr_n = 0;
    tag_n = 0;
    applyStimulus(1'b1, 16'h1234, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      v = (c >= 5);
      applyStimulus(1'b0, 16'h1234, v);
      if (write_data_array) wr_n++;
      if (write_tag_array) tag_n++;
    end
    checkOutput("abort.writes", wr_n, 3);
    checkOutput("abort.tags", tag_n, 0);
    doReset("abort");
    runFill("refill", 16'h0008, 16'h0000, 0, 1'b0, 16'h0008);

    $display("[TB] top-of-memory line with spurious idle valid");
    applyStimulus(1'b0, 16'hFFFF, 1'b1);
    checkAll("spurious", 0, 0, 16'h0, 0, 3'd0, 0);
    runFill("top", 16'hFFFF, 16'hFFF0, 0, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("top.idle.busy", int'(fsm_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
